div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit integer divider for the MIPS ALU datapath; executes DIV/DIVU, the inverse operation to the multiply unit.
- Dividend SrcA and divisor SrcB are captured on a level validIn handshake; radix-2 restoring division runs for 32 cycles.
- Delivers quotient on Lo and remainder on Hi with a validOut level, matching the Hi/Lo writeback path used by multiply.

Parameters:
- WIDTH, 32, operand width. Quotient and remainder are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- validIn  input  1  request level; high starts the operation and must stay high until the result is consumed
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with operands
- SrcA  input  WIDTH  dividend; sampled when validIn is first seen in IDLE
- SrcB  input  WIDTH  divisor; sampled with SrcA
- validOut  output  1  result valid; level signal
- busy  output  1  high in ITER
- divByZero  output  1  high with validOut when captured divisor == 0
- Hi  output  WIDTH  remainder
- Lo  output  WIDTH  quotient

Behaviour:
- Reset (rst_n low, async): state=IDLE. validOut=0, busy=0, divByZero=0, Hi=0, Lo=0. Internal registers are cleared.
- States: IDLE, ITER, DONE.
- IDLE:
  - On a clk edge with validIn=1: capture sign, neg_a=sign&SrcA[31], neg_b=sign&SrcB[31].
  - Capture magnitudes |SrcA| and |SrcB| (two's-complement negate when negative), remainder=0, count=0.
  - Go to ITER.
- ITER, each cycle:
  - rem_shift={rem[W-2:0], dvd[W-1]}.
  - If rem_shift >= dvs: rem=rem_shift-dvs and quotient bit=1. Otherwise rem=rem_shift and quotient bit=0.
  - Shift the quotient bit into dvd LSB; count++.
  - On the edge where count reaches WIDTH-1, apply sign fixup to the final values, register Hi/Lo/divByZero, and go to DONE.
- Sign fixup:
  - Lo = (neg_a^neg_b) ? -q : q.
  - Hi = neg_a ? -r : r. The remainder sign follows the dividend.
- Latency: validIn sampled at edge 0 gives validOut=1 after edge 32, i.e. 32 clocks.
- DONE:
  - validOut=1 and Hi/Lo are held stable while validIn=1.
  - validIn=0 returns to IDLE next edge; validOut drops that edge. Hi/Lo keep their last value.
  - A new operation requires validIn low for at least one cycle.
- Abort: validIn=0 during ITER returns to IDLE next edge. validOut is never asserted and Hi/Lo are unchanged.
- Divide by zero: the natural restoring result is kept (q=all ones, r=|SrcA|), then the same sign fixup is applied; divByZero=1. The divider never hangs.
- Signed overflow (0x80000000 / -1): Lo=0x80000000, Hi=0, produced by wrap-around. No flag.
- Operand changes after capture are ignored. The sign input is only sampled in IDLE.
- rst_n asserted mid-ITER or mid-DONE: immediate IDLE, all outputs 0.

Decomposition:
- Package div_pkg:
  - state enum div_state_t {IDLE, ITER, DONE}
  - WIDTH-derived constant CNT_W = $clog2(WIDTH)
  - localparam DIV_LAT = WIDTH
- Sub-module div_step (combinational):
  - Inputs: rem, dvd MSB, dvs.
  - Outputs: next rem, quotient bit.
  - Isolates the compare/subtract so a radix-4 variant can later instantiate two of them.
- Top div_unit holds the FSM, counter, operand/sign registers and fixup.

Test Plan:
- Unsigned: sign=0, SrcA=100, SrcB=7 -> after 32 clocks validOut=1, Lo=14, Hi=2, divByZero=0. validOut stays high until validIn drops, then goes low next edge.
- Signed mixed: sign=1, SrcA=-7 (0xFFFFFFF9), SrcB=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Then SrcA=7, SrcB=-2 -> Lo=-3, Hi=1.
- Unsigned large: sign=0, SrcA=0xFFFFFFFF, SrcB=0x10 -> Lo=0x0FFFFFFF, Hi=0xF. The same operands with sign=1 -> Lo=0, Hi=0xFFFFFFFF.
- Boundaries:
  - SrcB=0, SrcA=5, sign=0 -> Lo=0xFFFFFFFF, Hi=5, divByZero=1.
  - sign=1, SrcA=0x80000000, SrcB=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Abort and reset:
  - validIn dropped at cycle 10 of ITER -> IDLE next edge, validOut never rises, Hi/Lo hold their previous values.
  - rst_n pulsed low mid-ITER, asynchronously and between clock edges -> outputs 0 immediately.
  - A subsequent request of 9/3 -> Lo=3, Hi=0 after 32 clocks.
- Operand stability: change SrcA/SrcB every cycle during ITER -> result matches the operands captured at start.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// The FSM encoding and the default operand width live here.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_LAT = 32;
  localparam int CNT_W   = $clog2(DIV_LAT);

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
// The shifted remainder is kept WIDTH+1 bits wide so divisors with the MSB set compare correctly.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {1'b0, i_dvs};

  // Remainder is always below the divisor, so a borrow out of the extra bit means shift < divisor.
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned 32-cycle restoring divider for DIV/DIVU.
// Quotient is returned on Lo and remainder on Hi, held while validIn stays high.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic             busy,
  output logic             divByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_count;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_dbz;

  logic             w_capture;
  logic             w_step;
  logic             w_last;
  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_qbit;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_capture = (r_state == IDLE) && validIn;
  assign w_step    = (r_state == ITER) && validIn;
  assign w_last    = w_step && (r_count == LAST_CNT);

  assign w_neg_a = sign & SrcA[WIDTH-1];
  assign w_neg_b = sign & SrcB[WIDTH-1];
  assign w_abs_a = w_neg_a ? ('0 - SrcA) : SrcA;
  assign w_abs_b = w_neg_b ? ('0 - SrcB) : SrcB;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_dvs     (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  // Fixup works on the values produced by the final step, so the result lands on the same edge.
  assign w_q_fin  = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_lo_fix = (r_neg_a ^ r_neg_b) ? ('0 - w_q_fin) : w_q_fin;
  assign w_hi_fix = r_neg_a ? ('0 - w_rem_nxt) : w_rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (validIn) w_next = ITER;
      ITER: begin
        if (!validIn)    w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    if (!validIn) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    validOut  = 1'b0;
    busy      = 1'b0;
    divByZero = 1'b0;
    case (r_state)
      ITER:    busy = 1'b1;
      DONE: begin
        validOut  = 1'b1;
        divByZero = r_dbz;
      end
      default: ;
    endcase
  end

  assign Hi = r_hi;
  assign Lo = r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_count <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_capture) begin
      r_rem   <= '0;
      r_dvd   <= w_abs_a;
      r_dvs   <= w_abs_b;
      r_count <= '0;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
    end else if (w_step) begin
      r_rem   <= w_rem_nxt;
      r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_lo  <= w_lo_fix;
        r_hi  <= w_hi_fix;
        r_dbz <= (r_dvs == '0);
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// overflow wrap, abort, asynchronous reset and operand stability.
module tb_div_unit;

  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         validIn = 1'b0;
  logic         sign    = 1'b0;
  logic [W-1:0] SrcA    = '0;
  logic [W-1:0] SrcB    = '0;
  logic         validOut;
  logic         busy;
  logic         divByZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .validIn   (validIn),
    .sign      (sign),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .validOut  (validOut),
    .busy      (busy),
    .divByZero (divByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 clk = ~clk;

  // Starts a request and returns #1 after edge 31 (one edge before the result is due).
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    sign    = s;
    SrcA    = a;
    SrcB    = b;
    validIn = 1'b1;
    repeat (32) @(posedge clk);
    #1;
  endtask

  task automatic release_req();
    @(negedge clk);
    validIn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (validOut !== 1'b0 || busy !== 1'b0 || divByZero !== 1'b0 || Hi !== '0 || Lo !== '0) begin
      n_fail++;
      $display("FAIL reset_state: vo=%b busy=%b dbz=%b Hi=%h Lo=%h, required all 0",
               validOut, busy, divByZero, Hi, Lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: vo=%b busy=%b, required 0/0", validOut, busy);
    end
  endtask

  task automatic test_unsigned();
    launch(1'b0, 32'd100, 32'd7);
    n_checks++;
    if (validOut !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL unsigned_latency: vo=%b busy=%b at edge 31, required 0/1", validOut, busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || busy !== 1'b0 || Lo !== 32'd14 || Hi !== 32'd2 || divByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL unsigned_result: vo=%b busy=%b Lo=%h Hi=%h dbz=%b, required 1/0 Lo=e Hi=2 dbz=0",
               validOut, busy, Lo, Hi, divByZero);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'd14 || Hi !== 32'd2) begin
      n_fail++;
      $display("FAIL unsigned_hold: vo=%b Lo=%h Hi=%h, required 1 e 2", validOut, Lo, Hi);
    end
    release_req();
    n_checks++;
    if (validOut !== 1'b0 || Lo !== 32'd14 || Hi !== 32'd2) begin
      n_fail++;
      $display("FAIL unsigned_release: vo=%b Lo=%h Hi=%h, required 0 e 2", validOut, Lo, Hi);
    end
  endtask

  task automatic test_signed();
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL signed_neg_dividend: vo=%b Lo=%h Hi=%h, required 1 fffffffd ffffffff",
               validOut, Lo, Hi);
    end
    release_req();
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'hFFFF_FFFD || Hi !== 32'd1) begin
      n_fail++;
      $display("FAIL signed_neg_divisor: vo=%b Lo=%h Hi=%h, required 1 fffffffd 1", validOut, Lo, Hi);
    end
    release_req();
  endtask

  task automatic test_large();
    launch(1'b0, 32'hFFFF_FFFF, 32'h10);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'h0FFF_FFFF || Hi !== 32'hF) begin
      n_fail++;
      $display("FAIL large_unsigned: vo=%b Lo=%h Hi=%h, required 1 0fffffff f", validOut, Lo, Hi);
    end
    release_req();
    launch(1'b1, 32'hFFFF_FFFF, 32'h10);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'h0 || Hi !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL large_signed: vo=%b Lo=%h Hi=%h, required 1 0 ffffffff", validOut, Lo, Hi);
    end
    release_req();
    launch(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'h0 || Hi !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL large_divisor: vo=%b Lo=%h Hi=%h, required 1 0 fffffffe", validOut, Lo, Hi);
    end
    release_req();
  endtask

  task automatic test_div_zero();
    launch(1'b0, 32'd5, 32'd0);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || divByZero !== 1'b1 || Lo !== 32'hFFFF_FFFF || Hi !== 32'd5) begin
      n_fail++;
      $display("FAIL div_zero: vo=%b dbz=%b Lo=%h Hi=%h, required 1 1 ffffffff 5",
               validOut, divByZero, Lo, Hi);
    end
    release_req();
    n_checks++;
    if (divByZero !== 1'b0 || validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL div_zero_release: dbz=%b vo=%b, required 0 0", divByZero, validOut);
    end
  endtask

  task automatic test_overflow();
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'h8000_0000 || Hi !== 32'h0 || divByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: vo=%b Lo=%h Hi=%h dbz=%b, required 1 80000000 0 0",
               validOut, Lo, Hi, divByZero);
    end
    release_req();
  endtask

  task automatic test_abort();
    logic seen;
    @(negedge clk);
    sign    = 1'b0;
    SrcA    = 32'd50;
    SrcB    = 32'd5;
    validIn = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    validIn = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || validOut !== 1'b0 || Lo !== 32'h8000_0000 || Hi !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b vo=%b Lo=%h Hi=%h, required 0 0 80000000 0",
               busy, validOut, Lo, Hi);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (validOut !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || Lo !== 32'h8000_0000 || Hi !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_quiet: validOut_seen=%b Lo=%h Hi=%h, required 0 80000000 0", seen, Lo, Hi);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sign    = 1'b0;
    SrcA    = 32'd1000;
    SrcB    = 32'd3;
    validIn = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || validOut !== 1'b0 || divByZero !== 1'b0 || Lo !== '0 || Hi !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b vo=%b dbz=%b Lo=%h Hi=%h, required all 0",
               busy, validOut, divByZero, Lo, Hi);
    end
    validIn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 32'd9, 32'd3);
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'd3 || Hi !== 32'd0) begin
      n_fail++;
      $display("FAIL after_reset: vo=%b Lo=%h Hi=%h, required 1 3 0", validOut, Lo, Hi);
    end
    release_req();
  endtask

  task automatic test_stability();
    @(negedge clk);
    sign    = 1'b0;
    SrcA    = 32'd1000;
    SrcB    = 32'd9;
    validIn = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      SrcA = $urandom;
      SrcB = $urandom;
      sign = ~sign;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b1 || Lo !== 32'd111 || Hi !== 32'd1) begin
      n_fail++;
      $display("FAIL operand_stability: vo=%b Lo=%h Hi=%h, required 1 6f 1", validOut, Lo, Hi);
    end
    release_req();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_large();
    test_div_zero();
    test_overflow();
    test_abort();
    test_async_reset();
    test_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
